pixel_word_packer: RTL

//  Write-side counterpart of the pixel-lane selection datapath: accepts processed 8-bit

---
 rtl/pixel_word_packer_pkg.sv | 21 ++
 rtl/pixel_word_packer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pixel_word_packer_pkg.sv
// rtl/pixel_word_packer_pkg.sv - shared state encoding, default widths and helpers for the pixel packer
package pixel_word_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_t;

    localparam int PIX_W_DEF     = 8;
    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 32;
    localparam int ADDR_STEP_DEF = 4;

    // Lane counter width; never zero so a single-lane build still has a counter.
    function automatic int cnt_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/pixel_word_packer.sv
// rtl/pixel_word_packer.sv - packs PIX_W pixels into DATA_W words and writes them to memory via req/ack
module pixel_word_packer
    import pixel_word_packer_pkg::*;
#(
    parameter int PIX_W     = PIX_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [PIX_W-1:0]         pix_data,
    input  logic                     pix_valid,
    input  logic                     pix_last,
    output logic                     pix_ready,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [DATA_W/PIX_W-1:0]  mem_be,
    input  logic                     mem_ack,
    output logic                     busy,
    output logic                     done
);

    localparam int LANES = DATA_W / PIX_W;
    localparam int CNT_W = cnt_width(LANES);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    pack_state_t        state_q, state_d;
    logic [CNT_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LANES-1:0]   be_q, be_d;
    logic               last_seen_q, last_seen_d;

    // Strobes shared with the per-lane registers.
    logic               lane_clr;
    logic               pix_fire;

    // Next-state and datapath control for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        addr_d      = addr_q;
        be_d        = be_q;
        last_seen_d = last_seen_q;
        lane_clr    = 1'b0;
        pix_fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    lane_clr    = 1'b1;
                    lane_cnt_d  = '0;
                    be_d        = '0;
                    last_seen_d = 1'b0;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (pix_valid) begin
                    pix_fire         = 1'b1;
                    be_d[lane_cnt_q] = 1'b1;
                    lane_cnt_d       = lane_cnt_q + CNT_W'(1);
                    last_seen_d      = pix_last;
                    if ((lane_cnt_q == LAST_LANE) || pix_last) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    addr_d     = addr_q + ADDR_W'(ADDR_STEP);
                    lane_clr   = 1'b1;
                    lane_cnt_d = '0;
                    be_d       = '0;
                    state_d    = last_seen_q ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, address pointer, byte enables and lane counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lane_cnt_q  <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            last_seen_q <= last_seen_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PIX_W-1:0] lane_q, lane_d;

        // Lane k captures the pixel accepted while the counter points at it.
        always_comb begin
            lane_d = lane_q;
            if (lane_clr) begin
                lane_d = '0;
            end else if (pix_fire && (lane_cnt_q == CNT_W'(k))) begin
                lane_d = pix_data;
            end
        end

        // Lane k storage register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_q <= '0;
            end else begin
                lane_q <= lane_d;
            end
        end

        assign mem_wdata[k*PIX_W +: PIX_W] = lane_q;
    end

    assign pix_ready = (state_q == ST_FILL);
    assign mem_req   = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;

endmodule
